// File: rtl/ow_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level 1-Wire bus master between N_REQ requesters.
// Define OW_ARB_TIMEOUT_EN to build the per-grant watchdog (TIMEOUT_CYCLES).
module ow_bus_arbiter #(
  parameter int N_REQ          = 2,
  parameter int IDLE_GAP       = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   wr_i,
  input  logic [N_REQ-1:0]   rd_i,
  input  logic [8*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   rd_strb_o,
  output logic [7:0]         rdata_o,
  output logic [N_REQ-1:0]   timeout_o,
  output logic               m_wr,
  output logic               m_rd,
  output logic [7:0]         m_data_o,
  input  logic               m_busy,
  input  logic               m_rd_strb,
  input  logic [7:0]         m_data_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;
  localparam logic [IW-1:0] PTR_RST  = IW'(N_REQ - 1);
  localparam logic [IW:0]   NQ       = (IW+1)'(N_REQ);
  localparam logic [3:0]    GAP_LAST = 4'(IDLE_GAP - 1);

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [3:0]       gap_q, gap_d;

  // Rotate requests so bit 0 is the requester just after the last owner.
  logic [N_REQ-1:0] req_rot;
  logic [IW:0]      rot_amt;
  logic             pick_vld;
  logic [IW-1:0]    pick_off;
  logic [IW:0]      pick_sum;
  logic [IW:0]      pick_wrap;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_oh;

  assign rot_amt = {1'b0, ptr_q} + {{IW{1'b0}}, 1'b1};
  assign req_rot = N_REQ'({req, req} >> rot_amt);

  always_comb begin
    pick_vld = 1'b0;
    pick_off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        pick_vld = 1'b1;
        pick_off = IW'(j);
      end
    end
  end

  assign pick_sum  = rot_amt + {1'b0, pick_off};
  assign pick_wrap = (pick_sum >= NQ) ? (pick_sum - NQ) : pick_sum;
  assign pick_idx  = IW'(pick_wrap);
  assign pick_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;

`ifdef OW_ARB_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0] timeout_q, timeout_d;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = '0;
`endif

  logic arb_ok, own_req, take;
  assign arb_ok  = pick_vld & ~m_busy;
  assign own_req = |(req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    take    = 1'b0;
`ifdef OW_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = '0;
`endif
    case (state_q)
      S_IDLE: take = arb_ok;
      S_GRANT: begin
        if (!own_req) begin
          grant_d = '0;
          gap_d   = '0;
          state_d = m_busy ? S_DRAIN : S_GAP;
        end
`ifdef OW_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          timeout_d = grant_q;
          grant_d   = '0;
          state_d   = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      S_DRAIN: begin
        if (!m_busy) begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      default: begin
        // The last gap cycle is also the arbitration cycle, so exactly
        // IDLE_GAP grant-free cycles separate consecutive owners.
        if (gap_q == GAP_LAST) begin
          take = arb_ok;
          if (!arb_ok) state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
    endcase
    if (take) begin
      grant_d = pick_oh;
      ptr_d   = pick_idx;
      state_d = S_GRANT;
`ifdef OW_ARB_TIMEOUT_EN
      cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      gap_q   <= '0;
`ifdef OW_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
`ifdef OW_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  logic [7:0] data_and [N_REQ];
  logic       route_en;
  assign route_en = (state_q == S_GRANT) || (state_q == S_DRAIN);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign data_and[gi]  = data_i[8*gi +: 8] & {8{grant_q[gi]}};
      assign rd_strb_o[gi] = m_rd_strb & route_en & (ptr_q == IW'(gi));
    end
  endgenerate

  always_comb begin
    m_data_o = '0;
    for (int k = 0; k < N_REQ; k++) m_data_o = m_data_o | data_and[k];
  end

  assign grant   = grant_q;
  assign m_wr    = |(wr_i & grant_q);
  assign m_rd    = |(rd_i & grant_q);
  assign rdata_o = m_data_i;

endmodule
